// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and issues single-outstanding instruction reads.
// Redirects arriving mid-request mark the returned word for discard.
module instruction_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            phase_fetch,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] curr_pc_fd,
    output logic [XLEN-1:0] next_pc_fd,
    output logic            fetch_valid,
    output logic            stall_fetch
);

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            drop, drop_d;
    logic            req_d;
    logic [XLEN-1:0] addr_d;
    logic            capture;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] addr_inc;

    assign target      = {jump_target[XLEN-1:2], 2'b00};
    assign addr_inc    = imem_addr + FOUR;
    assign stall_fetch = (state == WAIT);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        drop_d  = drop;
        req_d   = imem_req;
        addr_d  = imem_addr;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (jump_taken) begin
                    pc_d = target;
                end
                if (phase_fetch) begin
                    req_d   = 1'b1;
                    addr_d  = jump_taken ? target : pc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                    // Stale word: keep the redirect PC, never fall through
                    if (jump_taken) begin
                        pc_d = target;
                    end else if (!drop) begin
                        pc_d    = addr_inc;
                        capture = 1'b1;
                    end
                end else if (jump_taken) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            inst        <= NOP;
            curr_pc_fd  <= RESET_PC;
            next_pc_fd  <= RESET_PC + FOUR;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            drop        <= drop_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            fetch_valid <= capture;
            if (capture) begin
                inst       <= imem_rdata;
                curr_pc_fd <= imem_addr;
                next_pc_fd <= addr_inc;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer end of the fetch-to-decode interface. Holds the architectural PC and issues single-outstanding read requests to instruction memory over a req/ack handshake.
- Registers the returned word together with its PC and PC+4 (`inst`, `curr_pc_fd`, `next_pc_fd`) for `instruction_decode`.
- Accepts branch/jump redirects from the execute stage, including while a request is in flight.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PC value loaded at reset

Ports:
- clk  in  1  CPU clock
- rst_n  in  1  reset, synchronous, active-low
- phase_fetch  in  1  start-fetch strobe from the phase sequencer
- jump_taken  in  1  redirect request from execute
- jump_target  in  XLEN  redirect address
- imem_req  out  1  instruction-memory read request
- imem_addr  out  XLEN  read address, word aligned
- imem_ack  in  1  memory response valid
- imem_rdata  in  32  returned instruction word
- inst  out  32  fetched instruction to decode
- curr_pc_fd  out  XLEN  address of `inst`
- next_pc_fd  out  XLEN  `curr_pc_fd` + 4
- fetch_valid  out  1  one-cycle pulse: new `inst`/PCs valid
- stall_fetch  out  1  high while a request is outstanding

Behaviour:
- Reset is synchronous, active-low. `rst_n`=0 at any rising edge forces all of the following; any ack pending at that edge is ignored:
  - state=IDLE, pc=RESET_PC, drop=0
  - imem_req=0, imem_addr=RESET_PC
  - inst=32'h0000_0013 (NOP), curr_pc_fd=RESET_PC, next_pc_fd=RESET_PC+4, fetch_valid=0
- Redirect: the effective next PC is jump_target with bits [1:0] forced to 0. Forcing the low bits is the only alignment handling; no exception is raised.
- State IDLE (imem_req=0):
  - phase_fetch=1 → next edge: imem_req=1; imem_addr=pc, or the aligned jump_target if jump_taken=1 in the same cycle; state=WAIT.
  - jump_taken=1 without phase_fetch → pc=aligned target; stay IDLE.
- State WAIT:
  - imem_req held 1 and imem_addr held stable until imem_ack is sampled 1.
  - phase_fetch is ignored.
  - stall_fetch = (state==WAIT), combinational.
- Ack in WAIT with drop=0 and jump_taken=0 → next edge:
  - inst=imem_rdata, curr_pc_fd=imem_addr, next_pc_fd=imem_addr+4
  - pc=imem_addr+4, fetch_valid=1 for exactly one cycle
  - imem_req=0, state=IDLE
- Jump in WAIT without ack → pc=aligned target, drop=1; request continues unchanged.
- Ack with drop=1, or ack and jump_taken in the same cycle:
  - Returned word discarded: inst and PC outputs hold, fetch_valid stays 0.
  - pc = the redirect target (the new target if jump_taken=1 this cycle, else the stored one); never imem_addr+4.
  - drop=0, imem_req=0, state=IDLE.
- Multiple jumps during one WAIT: the last target wins.
- Latency: phase_fetch sampled at edge N → imem_req high after N. Ack sampled at edge M≥N+1 → outputs update after M. Minimum 2 edges from phase_fetch to fetch_valid.
- Arithmetic: PC increment is modulo 2^XLEN (0xFFFF_FFFC+4 wraps to 0).
- Outputs `inst`/`curr_pc_fd`/`next_pc_fd` change only on an accepted ack or reset.
- fetch_valid, imem_req, imem_addr are registered; stall_fetch is the only combinational output.

Test Plan:
- Reset then phase_fetch, memory acks the cycle after req with rdata=32'h0050_0093 → imem_addr=0; after ack inst=32'h0050_0093, curr_pc_fd=0, next_pc_fd=4, fetch_valid one-cycle pulse; second fetch uses imem_addr=4.
- Slow memory: ack 5 cycles after req → imem_req and imem_addr constant for all 5 cycles, stall_fetch=1 throughout; phase_fetch pulses during WAIT cause no second request.
- Jump during WAIT (jump_target=32'h0000_0103): the in-flight ack is discarded (fetch_valid=0, inst unchanged); the next phase_fetch issues imem_addr=32'h0000_0100.
- jump_taken coincident with ack (target 32'h200) → no fetch_valid; next request at 32'h200. jump_taken coincident with phase_fetch in IDLE (target 32'h300) → request issued directly at 32'h300.
- RESET_PC=32'hFFFF_FFFC, fetch completes → next_pc_fd=0, next request address 0.
- rst_n low for one edge during WAIT with ack asserted the same cycle → outputs return to reset values (inst=32'h13, fetch_valid=0, imem_req=0); the ack is not captured.
